// File: rtl/write_bus_arbiter_pkg.sv
// write_bus_arbiter_pkg: shared widths, source IDs and round-robin helpers
// for the register-file write-back arbiter.
package write_bus_arbiter_pkg;
    localparam int WORD_WIDTH    = 32;
    localparam int REG_SEL_WIDTH = 5;

    typedef enum logic [1:0] {
        SRC_LEFT  = 2'd0,
        SRC_RIGHT = 2'd1,
        SRC_THIRD = 2'd2
    } src_id_t;

    function automatic src_id_t rr_next(src_id_t s);
        return s == SRC_LEFT ? SRC_RIGHT : s == SRC_RIGHT ? SRC_THIRD : SRC_LEFT;
    endfunction

    // First requester at or after ptr; caller qualifies with |req.
    function automatic src_id_t rr_pick(logic [2:0] req, src_id_t ptr);
        src_id_t s1 = rr_next(ptr);
        src_id_t s2 = rr_next(s1);
        return req[ptr] ? ptr : req[s1] ? s1 : s2;
    endfunction
endpackage

// File: rtl/write_bus_arbiter_if.sv
// write_bus_arbiter_if: producer handshakes plus the shared write bus.
// Forwarding selects/controls exist only when WBARB_FORWARD_EN is defined.
interface write_bus_arbiter_if
    import write_bus_arbiter_pkg::*;
#(
    parameter int WordWidth   = WORD_WIDTH,
    parameter int RegSelWidth = REG_SEL_WIDTH
);
    logic                   in_LeftValid, in_RightValid, in_ThirdValid;
    logic [WordWidth-1:0]   in_LeftData, in_RightData, in_ThirdData;
    logic [RegSelWidth-1:0] in_LeftDest, in_RightDest, in_ThirdDest;
    logic                   out_LeftReady, out_RightReady, out_ThirdReady;
    logic                   out_WriteEnable;
    logic [WordWidth-1:0]   out_WriteBus;
    logic [RegSelWidth-1:0] out_WriteDest;
    logic [1:0]             out_WriteSource;
`ifdef WBARB_FORWARD_EN
    logic [RegSelWidth-1:0] in_LeftReadSel, in_RightReadSel, in_ThirdReadSel;
    logic                   out_WriteToLeftRead, out_WriteToRightRead, out_WriteToThirdRead;
`endif

    modport master (
`ifdef WBARB_FORWARD_EN
        output in_LeftReadSel, in_RightReadSel, in_ThirdReadSel,
        input  out_WriteToLeftRead, out_WriteToRightRead, out_WriteToThirdRead,
`endif
        output in_LeftValid, in_RightValid, in_ThirdValid,
        output in_LeftData, in_RightData, in_ThirdData,
        output in_LeftDest, in_RightDest, in_ThirdDest,
        input  out_LeftReady, out_RightReady, out_ThirdReady,
        input  out_WriteEnable, out_WriteBus, out_WriteDest, out_WriteSource
    );

    modport slave (
`ifdef WBARB_FORWARD_EN
        input  in_LeftReadSel, in_RightReadSel, in_ThirdReadSel,
        output out_WriteToLeftRead, out_WriteToRightRead, out_WriteToThirdRead,
`endif
        input  in_LeftValid, in_RightValid, in_ThirdValid,
        input  in_LeftData, in_RightData, in_ThirdData,
        input  in_LeftDest, in_RightDest, in_ThirdDest,
        output out_LeftReady, out_RightReady, out_ThirdReady,
        output out_WriteEnable, out_WriteBus, out_WriteDest, out_WriteSource
    );
endinterface

// File: rtl/write_bus_arbiter_wb_source_fifo.sv
// wb_source_fifo: per-producer FIFO of {dest, data} with a registered full flag,
// so Ready never depends on a same-cycle pop.
module wb_source_fifo #(
    parameter int Width = 37,
    parameter int Depth = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] din,
    output logic [Width-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(Depth);

    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d   = wr_q + AW'(push);
        rd_d   = rd_q + AW'(pop);
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        full_d = cnt_d == (AW+1)'(Depth);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q  <= '{default: '0};
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign empty = cnt_q == '0;
    assign full  = full_q;
endmodule

// File: rtl/write_bus_arbiter.sv
// write_bus_arbiter: three buffered producers share one registered write bus
// under round-robin grant. Optional forwarding selects under WBARB_FORWARD_EN.
module write_bus_arbiter
    import write_bus_arbiter_pkg::*;
#(
    parameter int WordWidth   = WORD_WIDTH,
    parameter int RegSelWidth = REG_SEL_WIDTH,
    parameter int FifoDepth   = 2
) (
    input logic               clock,
    input logic               reset,
    write_bus_arbiter_if.slave bus
);
    localparam int EW = WordWidth + RegSelWidth;

    logic [2:0]             valid, push, pop, empty, full, req;
    logic [EW-1:0]          din [3];
    logic [EW-1:0]          head [3];
    src_id_t                rr_q, rr_d, src_q, src_d, grant;
    logic                   we_q, we_d;
    logic [WordWidth-1:0]   data_q, data_d;
    logic [RegSelWidth-1:0] dest_q, dest_d;

    assign valid  = {bus.in_ThirdValid, bus.in_RightValid, bus.in_LeftValid};
    assign din[0] = {bus.in_LeftDest, bus.in_LeftData};
    assign din[1] = {bus.in_RightDest, bus.in_RightData};
    assign din[2] = {bus.in_ThirdDest, bus.in_ThirdData};
    assign push   = valid & ~full;

    for (genvar i = 0; i < 3; i++) begin : g_fifo
        wb_source_fifo #(.Width(EW), .Depth(FifoDepth)) u_fifo (
            .clock(clock),
            .reset(reset),
            .push (push[i]),
            .pop  (pop[i]),
            .din  (din[i]),
            .dout (head[i]),
            .empty(empty[i]),
            .full (full[i])
        );
    end

    always_comb begin
        req   = ~empty;
        grant = rr_pick(req, rr_q);
        we_d  = |req;
        pop   = '0;
        if (we_d) pop[grant] = 1'b1;
        rr_d  = we_d ? rr_next(grant) : rr_q;
        src_d = we_d ? grant : src_q;
        {dest_d, data_d} = we_d ? head[grant] : {dest_q, data_q};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_q   <= SRC_LEFT;
            src_q  <= SRC_LEFT;
            we_q   <= 1'b0;
            data_q <= '0;
            dest_q <= '0;
        end else begin
            rr_q   <= rr_d;
            src_q  <= src_d;
            we_q   <= we_d;
            data_q <= data_d;
            dest_q <= dest_d;
        end
    end

    assign bus.out_LeftReady   = ~full[0];
    assign bus.out_RightReady  = ~full[1];
    assign bus.out_ThirdReady  = ~full[2];
    assign bus.out_WriteEnable = we_q;
    assign bus.out_WriteBus    = data_q;
    assign bus.out_WriteDest   = dest_q;
    assign bus.out_WriteSource = src_q;

`ifdef WBARB_FORWARD_EN
    // Registered with the bus so a match appears in the same cycle as the write.
    logic [2:0] fwd_q, fwd_d;

    always_comb begin
        fwd_d = {3{we_d}} & {dest_d == bus.in_ThirdReadSel,
                             dest_d == bus.in_RightReadSel,
                             dest_d == bus.in_LeftReadSel};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) fwd_q <= '0;
        else        fwd_q <= fwd_d;
    end

    assign bus.out_WriteToLeftRead  = fwd_q[0];
    assign bus.out_WriteToRightRead = fwd_q[1];
    assign bus.out_WriteToThirdRead = fwd_q[2];
`endif
endmodule

// File: tb/tb_write_bus_arbiter.sv
// tb_write_bus_arbiter: producer queues feed the DUT, accepted items go to a
// per-source scoreboard that the write-bus monitor pops and compares.
module tb_write_bus_arbiter;
    import write_bus_arbiter_pkg::*;

    localparam int WW = 32;
    localparam int RW = 5;

    typedef struct packed {
        logic [RW-1:0] dest;
        logic [WW-1:0] data;
    } item_t;

    logic    clock = 1'b0;
    logic    reset = 1'b1;
    logic [2:0] vld = '0;
    item_t   cur [3] = '{default: '0};
    item_t   pend [3][$];
    item_t   sbq [3][$];
    src_id_t gnt_log [$];
    int      compared = 0;
    int      mismatched = 0;
    item_t   mexp;
    logic [2:0] rdy;

    always #5 clock = ~clock;

    write_bus_arbiter_if #(.WordWidth(WW), .RegSelWidth(RW)) bus ();

    write_bus_arbiter #(.WordWidth(WW), .RegSelWidth(RW), .FifoDepth(2)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.in_LeftValid  = vld[0];
    assign bus.in_RightValid = vld[1];
    assign bus.in_ThirdValid = vld[2];
    assign bus.in_LeftData   = cur[0].data;
    assign bus.in_RightData  = cur[1].data;
    assign bus.in_ThirdData  = cur[2].data;
    assign bus.in_LeftDest   = cur[0].dest;
    assign bus.in_RightDest  = cur[1].dest;
    assign bus.in_ThirdDest  = cur[2].dest;
    assign rdy = {bus.out_ThirdReady, bus.out_RightReady, bus.out_LeftReady};

`ifdef WBARB_FORWARD_EN
    logic [RW-1:0] rsel [3] = '{default: '0};
    assign bus.in_LeftReadSel  = rsel[0];
    assign bus.in_RightReadSel = rsel[1];
    assign bus.in_ThirdReadSel = rsel[2];
`endif

    // Producers: an item is accepted on Valid&Ready at the edge; next item offered 1ns later.
    always @(posedge clock) begin
        for (int s = 0; s < 3; s++)
            if (reset && vld[s] && rdy[s] && pend[s].size() > 0)
                sbq[s].push_back(pend[s].pop_front());
        #1;
        for (int s = 0; s < 3; s++) begin
            vld[s] = pend[s].size() > 0;
            if (pend[s].size() > 0) cur[s] = pend[s][0];
        end
    end

    always @(negedge clock) begin
        if (reset && bus.out_WriteEnable) begin
            gnt_log.push_back(src_id_t'(bus.out_WriteSource));
            compared++;
            if (bus.out_WriteSource == 2'd3 || sbq[bus.out_WriteSource].size() == 0) begin
                mismatched++;
                $display("FAIL write_unexpected src=%0d data=%h dest=%0d expected no write",
                         bus.out_WriteSource, bus.out_WriteBus, bus.out_WriteDest);
            end else begin
                mexp = sbq[bus.out_WriteSource].pop_front();
                if ({bus.out_WriteDest, bus.out_WriteBus} !== mexp) begin
                    mismatched++;
                    $display("FAIL write_item src=%0d got dest=%0d data=%h exp dest=%0d data=%h",
                             bus.out_WriteSource, bus.out_WriteDest, bus.out_WriteBus,
                             mexp.dest, mexp.data);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            pend[s].delete();
            sbq[s].delete();
        end
        gnt_log.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((pend[0].size() + pend[1].size() + pend[2].size() +
                sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        compared++;
        if (n >= 200) begin
            mismatched++;
            $display("FAIL %s_drain got=timeout exp=all items written", name);
        end
    endtask

    task automatic test_reset();
        logic [42:0] got;
        #2 reset = 1'b0;
        @(negedge clock);
        compared++;
        if ({rdy, bus.out_WriteEnable} !== 4'b1110) begin
            mismatched++;
            $display("FAIL reset_held got rdy=%b we=%b exp rdy=111 we=0", rdy, bus.out_WriteEnable);
        end
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            got = {rdy, bus.out_WriteEnable, bus.out_WriteBus, bus.out_WriteDest, bus.out_WriteSource};
            compared++;
            if (got !== {3'b111, 1'b0, 32'h0, 5'd0, 2'd0}) begin
                mismatched++;
                $display("FAIL reset_idle cycle %0d got=%h exp=%h", c, got,
                         {3'b111, 1'b0, 32'h0, 5'd0, 2'd0});
            end
        end
    endtask

    task automatic test_single_write();
        logic [39:0] got;
        do_reset();
        pend[0].push_back('{dest: 5'd3, data: 32'hA5A5_0001});
        repeat (2) @(posedge clock);
        @(negedge clock);
        compared++;
        if (bus.out_WriteEnable !== 1'b0) begin
            mismatched++;
            $display("FAIL single_early got we=%b exp we=0", bus.out_WriteEnable);
        end
        @(negedge clock);
        got = {bus.out_WriteEnable, bus.out_WriteBus, bus.out_WriteDest, bus.out_WriteSource};
        compared++;
        if (got !== {1'b1, 32'hA5A5_0001, 5'd3, 2'd0}) begin
            mismatched++;
            $display("FAIL single_write got=%h exp=%h", got, {1'b1, 32'hA5A5_0001, 5'd3, 2'd0});
        end
        @(negedge clock);
        got = {bus.out_WriteEnable, bus.out_WriteBus, bus.out_WriteDest, bus.out_WriteSource};
        compared++;
        if (got !== {1'b0, 32'hA5A5_0001, 5'd3, 2'd0}) begin
            mismatched++;
            $display("FAIL idle_hold got=%h exp=%h", got, {1'b0, 32'hA5A5_0001, 5'd3, 2'd0});
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        do_reset();
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 6; i++)
                pend[s].push_back('{dest: RW'(s * 8 + i), data: WW'(32'hC0DE_0000 | (s << 8) | i)});
        while (gnt_log.size() < 18 && n < 100) begin
            @(negedge clock);
            n++;
        end
        compared++;
        if (gnt_log.size() < 18) begin
            mismatched++;
            $display("FAIL rr_timeout got=%0d writes exp=18", gnt_log.size());
        end else begin
            for (int i = 0; i < 18; i++) begin
                compared++;
                if (gnt_log[i] !== src_id_t'(i % 3)) begin
                    mismatched++;
                    $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, gnt_log[i], i % 3);
                end
            end
        end
        wait_drain("rr");
    endtask

    task automatic test_backpressure();
        logic exp_r [3] = '{1'b1, 1'b0, 1'b1};
        int rights = 0;
        do_reset();
        for (int i = 0; i < 4; i++) pend[0].push_back('{dest: RW'(i), data: WW'(32'h1111_0000 + i)});
        for (int i = 0; i < 3; i++) pend[1].push_back('{dest: RW'(16 + i), data: WW'(32'h2222_0000 + i)});
        @(posedge clock);
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            @(negedge clock);
            compared++;
            if (bus.out_RightReady !== exp_r[c]) begin
                mismatched++;
                $display("FAIL bp_right_ready step %0d got=%b exp=%b", c, bus.out_RightReady, exp_r[c]);
            end
        end
        wait_drain("bp");
        foreach (gnt_log[i]) if (gnt_log[i] == SRC_RIGHT) rights++;
        compared++;
        if (rights != 3) begin
            mismatched++;
            $display("FAIL bp_right_count got=%0d exp=3", rights);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 4; i++)
                pend[s].push_back('{dest: RW'(i + 4), data: WW'(32'hDEAD_0000 | (s << 8) | i)});
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            pend[s].delete();
            sbq[s].delete();
        end
        gnt_log.delete();
        #1;
        compared++;
        if ({rdy, bus.out_WriteEnable} !== 4'b1110) begin
            mismatched++;
            $display("FAIL midop_in_reset got rdy=%b we=%b exp rdy=111 we=0", rdy, bus.out_WriteEnable);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        compared++;
        if (rdy !== 3'b111) begin
            mismatched++;
            $display("FAIL midop_ready got=%b exp=111", rdy);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            compared++;
            if (bus.out_WriteEnable !== 1'b0) begin
                mismatched++;
                $display("FAIL midop_no_write cycle %0d got we=1 exp we=0", c);
            end
        end
        compared++;
        if (gnt_log.size() != 0) begin
            mismatched++;
            $display("FAIL midop_writes got=%0d exp=0", gnt_log.size());
        end
    endtask

`ifdef WBARB_FORWARD_EN
    task automatic test_forward();
        logic [3:0] got, exp;
        do_reset();
        rsel[0] = 5'd3;
        rsel[1] = 5'd7;
        rsel[2] = 5'd9;
        pend[2].push_back('{dest: 5'd7, data: 32'h7777_0007});
        @(posedge clock);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            got = {bus.out_WriteEnable, bus.out_WriteToThirdRead, bus.out_WriteToRightRead,
                   bus.out_WriteToLeftRead};
            exp = (k == 1) ? 4'b1010 : 4'b0000;
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL forward step %0d got we/T/R/L=%b exp=%b", k, got, exp);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_backpressure();
        test_reset_midop();
`ifdef WBARB_FORWARD_EN
        test_forward();
`endif
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
